// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory responder: dfunc size codes, extend bit, FSM state.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // dfunc bit that selects zero-extension (1) versus sign-extension (0) on loads.
  localparam int EXT_BIT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: big-endian byte enables, store replication, load extract/extend, fault.
module dmem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [2:0]  dfunc,
  input  logic [1:0]  offset,
  input  logic [31:0] din,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        fault
);

  logic        zext;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign zext = dfunc[EXT_BIT];

  // Offset 0 is the most significant byte of the word.
  always_comb begin
    sel_byte = rdata[31:24];
    case (offset)
      2'd0: sel_byte = rdata[31:24];
      2'd1: sel_byte = rdata[23:16];
      2'd2: sel_byte = rdata[15:8];
      2'd3: sel_byte = rdata[7:0];
      default: sel_byte = rdata[31:24];
    endcase
  end

  assign sel_half = offset[1] ? rdata[15:0] : rdata[31:16];

  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    ldata = 32'h0;
    fault = 1'b0;
    case (dfunc[1:0])
      SIZE_BYTE: begin
        be    = 4'b1000 >> offset;
        wdata = {4{din[7:0]}};
        ldata = zext ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      SIZE_HALF: begin
        fault = offset[0];
        be    = offset[0] ? 4'b0000 : (offset[1] ? 4'b0011 : 4'b1100);
        wdata = {2{din[15:0]}};
        ldata = zext ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      SIZE_WORD: begin
        fault = |offset;
        be    = (|offset) ? 4'b0000 : 4'b1111;
        wdata = din;
        ldata = rdata;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-cycle-response data memory. Build option DMEM_WRITE_BUFFER_EN routes stores
// through a one-entry write buffer with load forwarding.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        req,
  input  logic        rw,
  input  logic [2:0]  dfunc,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ready,
  output logic        fault,
  output state_t      state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rdata;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       ldata;
  logic              fault_c;
  logic              store_acc;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic              unused_addr;
  state_t            state;

  assign idx         = addr[ADDR_W+1:2];
  assign unused_addr = ^addr[31:ADDR_W+2];
  assign store_acc   = _reset & req & rw & ~fault_c;

  dmem_lane_align u_align (
    .dfunc  (dfunc),
    .offset (addr[1:0]),
    .din    (din),
    .rdata  (rdata),
    .be     (be),
    .wdata  (wdata),
    .ldata  (ldata),
    .fault  (fault_c)
  );

`ifdef DMEM_WRITE_BUFFER_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_idx;
  logic [3:0]        buf_be;
  logic [31:0]       buf_data;

  // The buffer drains on every non-reset edge, so a held entry never outlives one cycle.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      buf_valid <= 1'b0;
    end else begin
      buf_valid <= store_acc;
      if (store_acc) begin
        buf_idx  <= idx;
        buf_be   <= be;
        buf_data <= wdata;
      end
    end
  end

  always_comb begin
    rdata = mem[idx];
    if (buf_valid && (buf_idx == idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (buf_be[i]) rdata[8*i +: 8] = buf_data[8*i +: 8];
      end
    end
  end

  assign wr_en   = _reset & buf_valid;
  assign wr_idx  = buf_idx;
  assign wr_be   = buf_be;
  assign wr_data = buf_data;
`else
  assign rdata   = mem[idx];
  assign wr_en   = store_acc;
  assign wr_idx  = idx;
  assign wr_be   = be;
  assign wr_data = wdata;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Response registers: ready follows acceptance by one cycle; dout is zero unless a good load.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      state <= IDLE;
      ready <= 1'b0;
      fault <= 1'b0;
      dout  <= 32'h0;
    end else begin
      state <= req ? RESP : IDLE;
      ready <= req;
      fault <= req & fault_c;
      dout  <= (req && !rw && !fault_c) ? ldata : 32'h0;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: hand-computed responses checked with immediate assertions.
module tb_dmem_responder;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        _reset;
  logic        req;
  logic        rw;
  logic [2:0]  dfunc;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ready;
  logic        fault;
  state_t      state_dbg;

  int checks = 0;
  int errors = 0;

  localparam logic       LD = 1'b0;
  localparam logic       ST = 1'b1;
  localparam logic [2:0] BYTE_S = 3'b000;
  localparam logic [2:0] BYTE_Z = 3'b100;
  localparam logic [2:0] HALF_S = 3'b001;
  localparam logic [2:0] HALF_Z = 3'b101;
  localparam logic [2:0] WORD   = 3'b010;
  localparam logic [2:0] ILL    = 3'b011;

  dmem_responder #(.ADDR_W(10)) dut (
    .clk       (clk),
    ._reset    (_reset),
    .req       (req),
    .rw        (rw),
    .dfunc     (dfunc),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .ready     (ready),
    .fault     (fault),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input logic r, input logic f, input logic [31:0] d);
    check({tag, ".ready"}, {31'h0, ready}, {31'h0, r});
    check({tag, ".fault"}, {31'h0, fault}, {31'h0, f});
    check({tag, ".dout"}, dout, d);
  endtask

  // Drive one cycle of inputs at a falling edge; returns at the next falling edge,
  // when the response registered by the intervening rising edge is visible.
  task automatic step(input logic q, input logic w, input logic [2:0] df,
                      input logic [31:0] a, input logic [31:0] d);
    req   = q;
    rw    = w;
    dfunc = df;
    addr  = a;
    din   = d;
    @(negedge clk);
  endtask

  initial begin
    _reset = 1'b0;
    req = 1'b0; rw = 1'b0; dfunc = 3'b000; addr = 32'h0; din = 32'h0;
    @(negedge clk);
    // A request held during reset must be dropped.
    step(1'b1, LD, WORD, 32'h10, 32'h0);
    step(1'b1, LD, WORD, 32'h10, 32'h0);
    check_resp("reset", 1'b0, 1'b0, 32'h0);
    check("reset.state", {31'h0, state_dbg}, {31'h0, IDLE});
    _reset = 1'b1;
    step(1'b0, LD, WORD, 32'h0, 32'h0);
    check_resp("release", 1'b0, 1'b0, 32'h0);

    // Word store then back-to-back word load.
    step(1'b1, ST, WORD, 32'h10, 32'h11223344);
    check_resp("st_w10", 1'b1, 1'b0, 32'h0);
    check("st_w10.state", {31'h0, state_dbg}, {31'h0, RESP});
    step(1'b1, LD, WORD, 32'h10, 32'h0);
    check_resp("ld_w10", 1'b1, 1'b0, 32'h11223344);

    // Byte store into offset 1 (bits 23:16).
    step(1'b1, ST, BYTE_S, 32'h11, 32'h000000AB);
    check_resp("st_b11", 1'b1, 1'b0, 32'h0);
    step(1'b1, LD, WORD, 32'h10, 32'h0);
    check_resp("ld_w10b", 1'b1, 1'b0, 32'h11AB3344);
    step(1'b1, LD, BYTE_S, 32'h11, 32'h0);
    check_resp("ld_b11s", 1'b1, 1'b0, 32'hFFFFFFAB);
    step(1'b1, LD, BYTE_Z, 32'h11, 32'h0);
    check_resp("ld_b11z", 1'b1, 1'b0, 32'h000000AB);
    step(1'b1, LD, HALF_S, 32'h12, 32'h0);
    check_resp("ld_h12s", 1'b1, 1'b0, 32'h00003344);
    step(1'b1, LD, HALF_Z, 32'h10, 32'h0);
    check_resp("ld_h10z", 1'b1, 1'b0, 32'h000011AB);

    // Faults: misaligned half, misaligned word store, illegal size.
    step(1'b1, LD, HALF_S, 32'h13, 32'h0);
    check_resp("ld_h13", 1'b1, 1'b1, 32'h0);
    step(1'b1, ST, WORD, 32'h12, 32'hFFFFFFFF);
    check_resp("st_w12", 1'b1, 1'b1, 32'h0);
    step(1'b1, LD, ILL, 32'h10, 32'h0);
    check_resp("ld_ill", 1'b1, 1'b1, 32'h0);
    step(1'b1, LD, WORD, 32'h10, 32'h0);
    check_resp("ld_w10c", 1'b1, 1'b0, 32'h11AB3344);

    // Half store into the low half, then signed half readback.
    step(1'b1, ST, HALF_S, 32'h12, 32'h0000BEEF);
    check_resp("st_h12", 1'b1, 1'b0, 32'h0);
    step(1'b1, LD, WORD, 32'h10, 32'h0);
    check_resp("ld_w10d", 1'b1, 1'b0, 32'h11ABBEEF);
    step(1'b1, LD, HALF_S, 32'h12, 32'h0);
    check_resp("ld_h12b", 1'b1, 1'b0, 32'hFFFFBEEF);

    // Back-to-back store/load, consecutive stores, upper address bits ignored.
    step(1'b1, ST, WORD, 32'h20, 32'hDEADBEEF);
    check_resp("st_w20", 1'b1, 1'b0, 32'h0);
    step(1'b1, LD, WORD, 32'h20, 32'h0);
    check_resp("ld_w20", 1'b1, 1'b0, 32'hDEADBEEF);
    step(1'b1, ST, BYTE_S, 32'h23, 32'h00000055);
    check_resp("st_b23", 1'b1, 1'b0, 32'h0);
    step(1'b1, ST, BYTE_S, 32'h20, 32'h00000066);
    check_resp("st_b20", 1'b1, 1'b0, 32'h0);
    step(1'b1, LD, WORD, 32'h1000_0020, 32'h0);
    check_resp("ld_w20b", 1'b1, 1'b0, 32'h66ADBE55);
    step(1'b0, LD, WORD, 32'h0, 32'h0);
    check_resp("idle", 1'b0, 1'b0, 32'h0);
    check("idle.state", {31'h0, state_dbg}, {31'h0, IDLE});

    // Load accepted, then reset on the following edge: no response survives.
    step(1'b1, LD, WORD, 32'h20, 32'h0);
    _reset = 1'b0;
    step(1'b0, LD, WORD, 32'h0, 32'h0);
    check_resp("rst_after_acc", 1'b0, 1'b0, 32'h0);
    _reset = 1'b1;
    step(1'b0, LD, WORD, 32'h0, 32'h0);
    check_resp("post_reset", 1'b0, 1'b0, 32'h0);

    // Array survives reset.
    step(1'b1, LD, WORD, 32'h10, 32'h0);
    check_resp("ld_after_rst", 1'b1, 1'b0, 32'h11ABBEEF);
    step(1'b0, LD, WORD, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: ADDR_W, default 10, log2 of the number of 32-bit words in the data array.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: _reset  in  1  synchronous active-low reset.
REQ-004 Port: req  in  1  access request, sampled on each clk edge.
REQ-005 Port: rw  in  1  1 = store, 0 = load.
REQ-006 Port: dfunc  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2] 1 = zero-extend load, 0 = sign-extend.
REQ-007 Port: addr  in  32  byte address; bits [ADDR_W+1:2] select the word and upper bits are ignored.
REQ-008 Port: din  in  32  store data from the controller, right-justified.
REQ-009 Port: dout  out  32  load data to the controller, extended.
REQ-010 Port: ready  out  1  response valid, one cycle after acceptance.
REQ-011 Port: fault  out  1  alignment or illegal-size error, valid with ready.

Function
REQ-012 Byte order SHALL be big-endian: byte offset 0 maps to word bits [31:24].
REQ-013 A req sampled high SHALL be accepted in any state, giving a throughput of one access per cycle.
REQ-014 ready SHALL be 1 in exactly the cycle after acceptance and 0 otherwise.
REQ-015 A load SHALL present the selected byte, half or word on dout in the ready cycle, extended per dfunc[2].
REQ-016 A store SHALL update only the byte lanes selected by size and offset; unselected lanes are unchanged.
REQ-017 Fault conditions SHALL be: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
REQ-018 On fault, the block SHALL assert fault=1 with ready, drive dout=0, and perform no array or buffer update.
REQ-019 dout SHALL be 0 whenever ready=0.
REQ-020 A state machine SHALL have two states, IDLE and RESP: accept moves to RESP; RESP with no req returns to IDLE; RESP with req stays in RESP.
REQ-021 A load accepted the cycle after a store to the same word SHALL return the stored bytes.

Reset
REQ-022 With _reset=0 at a clk edge, the block SHALL enter IDLE with ready=0, fault=0, dout=0, and any write buffer invalid.
REQ-023 A request sampled during reset SHALL be dropped, and a request accepted the cycle before reset SHALL produce no response.
REQ-024 The data array SHALL not be reset, and its contents SHALL be undefined until written.

Configuration
REQ-025 Macro DMEM_WRITE_BUFFER_EN SHALL select how stores are committed.
- Defined: an accepted store SHALL enter a one-entry buffer {word addr, byte enables, data} instead of the array.
- Drain: the buffer SHALL drain to the array on any edge where no store is accepted; a store into a full buffer SHALL drain the old entry and load the new one on the same edge.
- Forwarding: a load matching the buffered word SHALL merge buffered lanes over array data.
- Reset: a pending buffered store SHALL be discarded on reset.
REQ-026 Undefined: a store SHALL write the array on its acceptance edge and there SHALL be no buffer logic.
REQ-027 The externally visible ready, fault and dout timing SHALL be identical with and without DMEM_WRITE_BUFFER_EN.

Structure
REQ-028 Shared package mips_mem_pkg SHALL hold the dfunc size encodings, the extend-bit position, and the state typedef.
REQ-029 Sub-module dmem_lane_align SHALL be purely combinational and compute byte enables, store data replication, load byte extraction with extension, and the fault flag.
REQ-030 The array SHALL use one synchronous write port and one read port.

Verification
REQ-031 Store word 0x11223344 to addr 0x10, then load word 0x10 -> ready=1, dout=0x11223344, fault=0.
REQ-032 Store byte 0xAB to 0x11, then load word 0x10 -> dout=0x11AB3344.
REQ-033 Load byte 0x11 with dfunc[2]=0 -> dout=0xFFFFFFAB; with dfunc[2]=1 -> dout=0x000000AB.
REQ-034 Load half from 0x13 -> fault=1, dout=0; a word store to 0x12 -> fault=1 and a later load of 0x10 is unchanged.
REQ-035 Store word 0xDEADBEEF to 0x20, then load 0x20 on the next cycle with back-to-back req -> dout=0xDEADBEEF in both build variants.
REQ-036 Accept a load, then assert _reset=0 on the next edge -> ready stays 0; after reset release with no req -> ready=0, fault=0, dout=0.
